// File: rtl/can_tx_mailbox.sv
// CAN transmit mailbox bank: holds up to NUM_MB frames, offers the arbitration winner to the TCU,
// and retires, retries or aborts it. Define CAN_TX_ID_PRIORITY_EN for ID-key selection (else lowest index).
module can_tx_mailbox #(
    parameter int NUM_MB = 3
) (
    input  logic              clk,
    input  logic              nRST,
    input  logic              wr_en,
    input  logic [1:0]        wr_idx,
    input  logic [28:0]       wr_ID,
    input  logic              wr_EXT,
    input  logic              wr_RTR,
    input  logic [3:0]        wr_pkt_size,
    input  logic [63:0]       wr_data,
    input  logic              abort_en,
    input  logic [1:0]        abort_idx,
    input  logic              tx_busy,
    input  logic              tx_done,
    input  logic              tx_arb_loss,
    output logic              tx_pkt_ready,
    output logic [28:0]       tx_ID,
    output logic [3:0]        tx_pkt_size,
    output logic              tx_RTR,
    output logic              tx_EXT,
    output logic [63:0]       tx_data,
    output logic [NUM_MB-1:0] mb_pending,
    output logic [NUM_MB-1:0] mb_sent,
    output logic [NUM_MB-1:0] mb_aborted,
    output logic              wr_reject
);

    typedef enum logic [1:0] {IDLE, SELECT, OFFER, ACTIVE} state_t;

    state_t r_state, w_state_next;

    logic [28:0]       r_mb_id   [NUM_MB];
    logic [3:0]        r_mb_dlc  [NUM_MB];
    logic [63:0]       r_mb_data [NUM_MB];
    logic [NUM_MB-1:0] r_mb_ext, r_mb_rtr;
    logic [NUM_MB-1:0] r_pending, r_sent, r_aborted;
    logic [1:0]        r_cur_idx;
    logic              r_abort_req, r_wr_reject;
    logic [28:0]       r_tx_id;
    logic [3:0]        r_tx_dlc;
    logic              r_tx_rtr, r_tx_ext;
    logic [63:0]       r_tx_data;

    logic [NUM_MB-1:0] w_accept, w_ab_hit, w_cur_sel, w_act_cur;
    logic [NUM_MB-1:0] w_done_clr, w_arb_abort, w_abort_set;
    logic [1:0]        w_win_idx;
    logic              w_found, w_cur_abort, w_act_abort, w_snap_en;
    logic [3:0]        w_dlc_clamped;

    assign w_dlc_clamped = (wr_pkt_size > 4'd8) ? 4'd8 : wr_pkt_size;

    // "Current" means the winner while in SELECT, the latched index in OFFER/ACTIVE.
    generate
        for (genvar gi = 0; gi < NUM_MB; gi++) begin : g_mb
            assign w_accept[gi]    = wr_en & (wr_idx == 2'(gi)) & ~r_pending[gi];
            assign w_ab_hit[gi]    = abort_en & (abort_idx == 2'(gi)) & r_pending[gi];
            assign w_cur_sel[gi]   = (r_state == SELECT) ? (w_found && (w_win_idx == 2'(gi)))
                                                         : ((r_state == OFFER) && (r_cur_idx == 2'(gi)));
            assign w_act_cur[gi]   = (r_state == ACTIVE) && (r_cur_idx == 2'(gi));
            assign w_done_clr[gi]  = w_act_cur[gi] & tx_done;
            assign w_arb_abort[gi] = w_act_cur[gi] & ~tx_done & tx_arb_loss & (r_abort_req | w_ab_hit[gi]);
            assign w_abort_set[gi] = (w_ab_hit[gi] & ~w_act_cur[gi]) | w_arb_abort[gi];
        end
    endgenerate

`ifdef CAN_TX_ID_PRIORITY_EN
    logic [31:0] w_key [NUM_MB];
    logic [31:0] w_best_key;

    generate
        for (genvar gi = 0; gi < NUM_MB; gi++) begin : g_key
            assign w_key[gi] = r_mb_ext[gi]
                ? {r_mb_id[gi][28:18], 2'b11, r_mb_id[gi][17:0], r_mb_rtr[gi]}
                : {r_mb_id[gi][10:0], r_mb_rtr[gi], 20'b0};
        end
    endgenerate

    // Strict less-than keeps ties with the lower index.
    always_comb begin
        w_found    = 1'b0;
        w_win_idx  = 2'd0;
        w_best_key = '1;
        for (int i = 0; i < NUM_MB; i++) begin
            if (r_pending[i] && (!w_found || (w_key[i] < w_best_key))) begin
                w_found    = 1'b1;
                w_win_idx  = 2'(i);
                w_best_key = w_key[i];
            end
        end
    end
`else
    always_comb begin
        w_found   = 1'b0;
        w_win_idx = 2'd0;
        for (int i = 0; i < NUM_MB; i++) begin
            if (r_pending[i] && !w_found) begin
                w_found   = 1'b1;
                w_win_idx = 2'(i);
            end
        end
    end
`endif

    assign w_cur_abort = |(w_ab_hit & w_cur_sel);
    assign w_act_abort = |(w_ab_hit & w_act_cur);
    assign w_snap_en   = (r_state == SELECT) && w_found && !w_cur_abort;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (|r_pending) w_state_next = SELECT;
            SELECT:  w_state_next = w_snap_en ? OFFER : IDLE;
            OFFER: begin
                if (w_cur_abort)  w_state_next = IDLE;
                else if (tx_busy) w_state_next = ACTIVE;
            end
            ACTIVE:  if (tx_done || tx_arb_loss) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_MB; i++) begin
            if (w_accept[i]) begin
                r_mb_id[i]   <= wr_ID;
                r_mb_dlc[i]  <= w_dlc_clamped;
                r_mb_data[i] <= wr_data;
                r_mb_ext[i]  <= wr_EXT;
                r_mb_rtr[i]  <= wr_RTR;
            end
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_state     <= IDLE;
            r_pending   <= '0;
            r_sent      <= '0;
            r_aborted   <= '0;
            r_cur_idx   <= 2'd0;
            r_abort_req <= 1'b0;
            r_wr_reject <= 1'b0;
            r_tx_id     <= '0;
            r_tx_dlc    <= '0;
            r_tx_rtr    <= 1'b0;
            r_tx_ext    <= 1'b0;
            r_tx_data   <= '0;
        end else begin
            r_state     <= w_state_next;
            r_wr_reject <= wr_en & ~|w_accept;
            r_pending   <= (r_pending & ~(w_done_clr | w_abort_set)) | w_accept;
            r_sent      <= (r_sent & ~w_accept) | w_done_clr;
            r_aborted   <= (r_aborted & ~w_accept) | w_abort_set;
            // A pending abort only matters until the current attempt resolves.
            if (r_state == ACTIVE && !tx_done && !tx_arb_loss)
                r_abort_req <= r_abort_req | w_act_abort;
            else
                r_abort_req <= 1'b0;
            if (w_snap_en) begin
                r_cur_idx <= w_win_idx;
                r_tx_id   <= r_mb_id[w_win_idx];
                r_tx_dlc  <= r_mb_dlc[w_win_idx];
                r_tx_data <= r_mb_data[w_win_idx];
                r_tx_rtr  <= r_mb_rtr[w_win_idx];
                r_tx_ext  <= r_mb_ext[w_win_idx];
            end
        end
    end

    assign tx_pkt_ready = (r_state == OFFER);
    assign tx_ID        = r_tx_id;
    assign tx_pkt_size  = r_tx_dlc;
    assign tx_RTR       = r_tx_rtr;
    assign tx_EXT       = r_tx_ext;
    assign tx_data      = r_tx_data;
    assign mb_pending   = r_pending;
    assign mb_sent      = r_sent;
    assign mb_aborted   = r_aborted;
    assign wr_reject    = r_wr_reject;

endmodule
